// File: rtl/fetch_decode_queue_pkg.sv
// Shared pipeline package used by the fetch stage, the fetch/decode queue
// and the decode stage.
//   XLEN     : architectural register / pc width (64)
//   ILEN     : instruction word width (32)
//   NOP_INSN : canonical NOP encoding (addi x0, x0, 0)
//   fdq_entry_t : one queued {pc, instruction} pair (96 bits)
package fetch_decode_queue_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
  } fdq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_storage.sv
// Storage array for the fetch/decode queue: DEPTH x 96-bit entries, one
// synchronous write port and one asynchronous read port. Contents are not
// reset; validity is tracked entirely by the controller.
//   clk     : rising-edge clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : entry to write
//   i_raddr : read address
//   o_rdata : entry at i_raddr (combinational)
module fdq_storage
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  fdq_entry_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fdq_entry_t    o_rdata
);

  fdq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch/decode queue: a DEPTH-entry FIFO of {pc, instruction} pairs between
// the fetch stage and the decode/register-file stage.
//
// Handshake: a push happens on a rising edge where in_valid && in_ready; a
// pop happens on a rising edge where out_valid && out_ready. in_ready depends
// only on occupancy (never on out_ready), so a full queue refuses a push even
// if it pops in the same cycle. flush discards everything and wins over any
// same-cycle push or pop.
//
// Ports:
//   clk             : rising-edge clock
//   reset           : asynchronous active-low reset
//   in_valid        : fetch presents a valid pc/instruction
//   pc_in           : pc of the fetched instruction
//   instruction_in  : fetched instruction word
//   in_ready        : queue can accept a push
//   out_valid       : head entry valid for decode
//   out_ready       : decode consumes the head
//   pc_out          : head pc (0 when empty)
//   instruction_out : head instruction (NOP when empty)
//   flush           : taken branch, discard all entries
//   count           : number of occupied entries
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [ILEN-1:0]          instruction_in,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          pc_out,
  output logic [ILEN-1:0]          instruction_out,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic       w_push;
  logic       w_pop;
  fdq_entry_t w_wdata;
  fdq_entry_t w_rdata;

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid  & in_ready;
  assign w_pop  = out_valid & out_ready;

  assign w_wdata.pc   = pc_in;
  assign w_wdata.insn = instruction_in;

  fdq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_push & ~flush),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Empty queue presents a harmless NOP at pc 0 so decode never sees stale
  // storage contents (including right after an asynchronous reset).
  assign pc_out          = out_valid ? w_rdata.pc   : '0;
  assign instruction_out = out_valid ? w_rdata.insn : NOP_INSN;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              in_valid;
  logic [XLEN-1:0]   pc_in;
  logic [ILEN-1:0]   instruction_in;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   pc_out;
  logic [ILEN-1:0]   instruction_out;
  logic              flush;
  logic [CW-1:0]     count;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .flush           (flush),
    .count           (count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"},     64'(count),           64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid),       64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),        64'd1);
    chk({tag, "_pc_out"},    pc_out,               64'd0);
    chk({tag, "_insn_out"},  64'(instruction_out), 64'h13);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [63:0] pc);
    in_valid       = v;
    pc_in          = pc;
    instruction_in = 32'hA000_0000 | pc[31:0];
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    pc_in     = '0;
    instruction_in = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // reset values before any clock edge
    #3;
    chk_reset_outputs("por");
    step();
    step();
    reset = 1'b1;

    // reset then idle
    step();
    step();
    chk_reset_outputs("idle");

    // fill: pcs 0,4,8,12 with out_ready=0
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 64'(i * 4));
      step();
      chk("fill_count", 64'(count), 64'(i + 1));
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_head_pc", pc_out, 64'd0);
    chk("full_head_insn", 64'(instruction_out), 64'hA000_0000);

    // fifth push refused
    drive_push(1'b1, 64'h10);
    step();
    chk("refused_count", 64'(count), 64'd4);
    chk("refused_head", pc_out, 64'd0);

    // full + pop + push same cycle: pop happens, push still refused
    drive_push(1'b1, 64'h99);
    out_ready = 1'b1;
    step();
    chk("full_popush_count", 64'(count), 64'd3);
    drive_push(1'b0, 64'h0);

    // drain remaining pcs 4,8,12
    for (int i = 1; i < 4; i++) begin
      chk("drain_pc", pc_out, 64'(i * 4));
      chk("drain_insn", 64'(instruction_out), 64'hA000_0000 | 64'(i * 4));
      step();
    end
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_out_valid", 64'(out_valid), 64'd0);
    chk("drained_insn_nop", 64'(instruction_out), 64'h13);
    chk("drained_pc_zero", pc_out, 64'd0);

    // pop while empty is a no-op
    step();
    chk("empty_pop_count", 64'(count), 64'd0);
    out_ready = 1'b0;
    drive_push(1'b1, 64'h100);
    step();
    exp_q.push_back(64'h100);
    chk("after_empty_pop_head", pc_out, 64'h100);
    chk("after_empty_pop_count", 64'(count), 64'd1);

    // streaming 10 pcs with in_valid=1/out_ready=1; pointers wrap repeatedly
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_push(1'b1, 64'h200 + 64'(k * 4));
      chk("stream_head", pc_out, exp_q[0]);
      void'(exp_q.pop_front());
      exp_q.push_back(64'h200 + 64'(k * 4));
      step();
      chk("stream_count", 64'(count), 64'd1);
    end
    drive_push(1'b0, 64'h0);
    chk("stream_last_head", pc_out, exp_q[0]);
    void'(exp_q.pop_front());
    step();
    chk("stream_end_count", 64'(count), 64'd0);
    chk("stream_q_empty", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;

    // flush with a same-edge push of 0x40
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 64'h300 + 64'(i * 4));
      step();
    end
    chk("preflush_count", 64'(count), 64'd3);
    drive_push(1'b1, 64'h40);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    drive_push(1'b0, 64'h0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_pc_out", pc_out, 64'd0);
    drive_push(1'b1, 64'h50);
    step();
    drive_push(1'b0, 64'h0);
    chk("postflush_head", pc_out, 64'h50);
    chk("postflush_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("postflush_drain", 64'(count), 64'd0);

    // mid-operation asynchronous reset with 2 entries queued
    drive_push(1'b1, 64'h60);
    step();
    drive_push(1'b1, 64'h64);
    step();
    drive_push(1'b0, 64'h0);
    chk("premid_count", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    reset = 1'b1;

    // first push accepted on first edge after release
    drive_push(1'b1, 64'h70);
    step();
    drive_push(1'b0, 64'h0);
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_head", pc_out, 64'h70);
    chk("post_rst_insn", 64'(instruction_out), 64'hA000_0070);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entry count; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low; clk is the only clock.
REQ-004 SHALL have port in_valid  input  1  fetch stage presents a valid instruction/pc pair.
REQ-005 SHALL have port pc_in  input  64  pc of the fetched instruction.
REQ-006 SHALL have port instruction_in  input  32  fetched instruction word.
REQ-007 SHALL have port in_ready  output  1  queue accepts a push this cycle.
REQ-008 SHALL have port out_valid  output  1  head entry is valid for decode.
REQ-009 SHALL have port out_ready  input  1  decode/register-file stage consumes the head.
REQ-010 SHALL have port pc_out  output  64  pc of the head entry.
REQ-011 SHALL have port instruction_out  output  32  instruction of the head entry.
REQ-012 SHALL have port flush  input  1  taken branch (PC_SRC from memory stage); discard all entries.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 SHALL push when in_valid and in_ready are both 1 at a rising edge.
REQ-015 SHALL pop when out_valid and out_ready are both 1 at a rising edge.
REQ-016 SHALL drive in_ready = (count < DEPTH); a full queue refuses a push even when a pop occurs in the same cycle.
REQ-017 SHALL drive out_valid = (count != 0).
REQ-018 SHALL give one-cycle latency: an entry pushed at edge N is visible on pc_out/instruction_out with out_valid=1 after edge N; there is no same-cycle bypass.
REQ-019 SHALL present the head entry combinationally from storage when out_valid=1.
REQ-020 SHALL drive instruction_out = 32'h00000013 (NOP) and pc_out = 0 when out_valid=0.
REQ-021 SHALL handle simultaneous push and pop while not full: count unchanged, both pointers advance.
REQ-022 SHALL wrap read and write pointers modulo DEPTH with no gap or duplicate entry.
REQ-023 SHALL, on flush=1 at an edge, set count to 0 and reset both pointers to 0, ignoring any same-cycle push or pop; flush has priority over all other operations.
REQ-024 SHALL treat a pop while empty and a push while full as no-ops: no pointer or count change.
REQ-025 SHALL preserve FIFO order: entries leave in exactly the order accepted.

Reset
REQ-026 SHALL, while reset=0, immediately force count=0, pointers=0, out_valid=0, in_ready=1, pc_out=0, instruction_out=NOP.
REQ-027 SHALL abandon all stored entries when reset asserts mid-operation; storage contents need not be cleared.
REQ-028 SHALL accept its first push on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL take XLEN=64, ILEN=32, and the NOP encoding 32'h00000013 from the shared pipeline package; the same package is used by the fetch and decode stages.
REQ-030 SHALL keep pointer/count control and the storage array in one module; a separate storage sub-module fdq_storage (DEPTH x 96-bit, one write port, async read) is permitted.

Verification
REQ-031 SHALL cover reset then idle: after reset release with no stimulus -> out_valid=0, in_ready=1, count=0, instruction_out=32'h00000013.
REQ-032 SHALL cover fill and drain: push pc 0,4,8,12 with out_ready=0 -> count=4, in_ready=0; a fifth push is refused; then set out_ready=1 -> pcs 0,4,8,12 emerge in order over 4 cycles and count returns to 0.
REQ-033 SHALL cover streaming: in_valid=1 and out_ready=1 continuously for 10 pcs -> count stays at 1 after the first edge and every pc appears exactly once, in order.
REQ-034 SHALL cover flush: 3 entries queued, flush=1 with in_valid=1 (pc 0x40) on the same edge -> count=0 and out_valid=0 next cycle, and pc 0x40 is never output.
REQ-035 SHALL cover wrap-around: 6 push/pop cycles with DEPTH=4 -> the pointers wrap and the head pcs match the push order.
REQ-036 SHALL cover mid-operation reset: with 2 entries queued, pulse reset low between edges -> outputs reach their reset values immediately without waiting for a clock edge.
